// File: rtl/axi_ddr3_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_ddr3_burst_master
// Brief    : Single-burst AXI initiator for the DDR3 slave port, with
//            beat tracking, ID/last/response checking and a wait-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ddr3_burst_master #(
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter int                        AXI_ID_WIDTH    = 4,
    parameter int                        AXI_BURST_WIDTH = 6,
    parameter int                        AXI_DATA_WIDTH  = 128,
    parameter int                        AXI_STRB_WIDTH  = 16,
    parameter logic [AXI_ID_WIDTH-1:0]   MASTER_ID       = 4'h1,
    parameter int                        TIMEOUT_CYCLES  = 4096
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        ddr_init_done,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_BURST_WIDTH-1:0]  cmd_len,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [AXI_STRB_WIDTH-1:0]   wr_strb,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_last,
    output logic                        rd_valid,
    input  logic                        rd_ready,
    output logic                        busy,
    output logic                        err,
    input  logic                        err_clr,
    output logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    output logic [AXI_ID_WIDTH-1:0]     awid,
    output logic [AXI_BURST_WIDTH-1:0]  awlen,
    output logic                        awvalid,
    input  logic                        awready,
    output logic [AXI_DATA_WIDTH-1:0]   wdata,
    output logic [AXI_STRB_WIDTH-1:0]   wstrb,
    output logic                        wvalid,
    input  logic                        wready,
    input  logic                        wlast,
    input  logic [AXI_ID_WIDTH-1:0]     bid,
    input  logic [1:0]                  bresp,
    input  logic                        bvalid,
    output logic                        bready,
    output logic [AXI_ADDR_WIDTH-1:0]   araddr,
    output logic [AXI_ID_WIDTH-1:0]     arid,
    output logic [AXI_BURST_WIDTH-1:0]  arlen,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [AXI_ID_WIDTH-1:0]     rid,
    input  logic [AXI_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rvalid,
    input  logic                        rlast,
    output logic                        rready
);

    localparam int                          c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0]          c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TMO_W-1:0]          c_TMO_ONE   = c_TMO_W'(1);
    localparam logic [AXI_BURST_WIDTH-1:0]  c_BEAT_ONE  = AXI_BURST_WIDTH'(1);
    localparam logic [AXI_ADDR_WIDTH-1:0]   c_ADDR_MASK = {{(AXI_ADDR_WIDTH-3){1'b1}}, 3'b000};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [AXI_ADDR_WIDTH-1:0]      r_addr;
    logic [AXI_BURST_WIDTH-1:0]     r_len;
    logic [AXI_BURST_WIDTH-1:0]     r_beat;
    logic [c_TMO_W-1:0]             r_tmo_cnt;
    logic                           r_err;
    logic                           r_run;
    logic                           w_hs;
    logic                           w_beat_hs;
    logic                           w_last_beat;
    logic                           w_err_set;
    logic                           w_accept;

    assign w_last_beat = (r_beat == r_len);
    assign busy        = (r_state != ST_IDLE);
    assign err         = r_err;
    assign awaddr      = r_addr;
    assign araddr      = r_addr;
    assign awlen       = r_len;
    assign arlen       = r_len;
    assign awid        = MASTER_ID;
    assign arid        = MASTER_ID;
    assign wdata       = wr_data;
    assign wstrb       = wr_strb;
    assign rd_data     = rdata;

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        wr_ready  = 1'b0;
        bready    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rd_valid  = 1'b0;
        rd_last   = 1'b0;
        w_hs      = 1'b0;
        w_beat_hs = 1'b0;
        w_err_set = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_run keeps cmd_ready low while reset is held
                cmd_ready = r_run & ddr_init_done;
                if (cmd_valid && r_run && ddr_init_done) begin
                    w_accept = 1'b1;
                    w_next   = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    w_hs   = 1'b1;
                    w_next = ST_W;
                end
            end
            ST_W: begin
                wvalid   = wr_valid;
                wr_ready = wready;
                if (wr_valid && wready) begin
                    w_hs      = 1'b1;
                    w_beat_hs = 1'b1;
                    if (wlast && !w_last_beat) w_err_set = 1'b1;
                    if (w_last_beat)           w_next    = ST_B;
                end
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_hs = 1'b1;
                    if (bresp != 2'b00 || bid != MASTER_ID) w_err_set = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_hs   = 1'b1;
                    w_next = ST_R;
                end
            end
            ST_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = w_last_beat;
                if (rvalid && rd_ready) begin
                    w_hs      = 1'b1;
                    w_beat_hs = 1'b1;
                    if (rid != MASTER_ID || rresp != 2'b00 || rlast != w_last_beat)
                        w_err_set = 1'b1;
                    if (w_last_beat) w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Watchdog: a stalled wait state aborts the burst
        if (r_state != ST_IDLE && !w_hs && r_tmo_cnt == c_TMO_LAST) begin
            w_err_set = 1'b1;
            w_next    = ST_IDLE;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_beat    <= '0;
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (w_accept) begin
                r_addr <= cmd_addr & c_ADDR_MASK;
                r_len  <= cmd_len;
            end
            if (r_state == ST_IDLE)
                r_beat <= '0;
            else if (w_beat_hs)
                r_beat <= r_beat + c_BEAT_ONE;
            if (w_next != r_state || w_hs)
                r_tmo_cnt <= '0;
            else if (r_state != ST_IDLE)
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            // A new error wins over a simultaneous clear
            r_err <= (r_err & ~err_clr) | w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr3_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ddr3_burst_master
// Brief    : Directed bench with AXI slave responder and transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ddr3_burst_master;

    localparam int AW = 32, IW = 4, BW = 6, DW = 128, SW = 16, TMO = 4096;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn, ddr_init_done, cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_len;
    logic [DW-1:0] wr_data, rd_data, wdata, rdata;
    logic [SW-1:0] wr_strb, wstrb;
    logic wr_valid, wr_ready, rd_last, rd_valid, rd_ready, busy, err, err_clr;
    logic [AW-1:0] awaddr, araddr;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [BW-1:0] awlen, arlen;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rlast, rready;
    logic [1:0] bresp, rresp;

    axi_ddr3_burst_master #(
        .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_BURST_WIDTH(BW),
        .AXI_DATA_WIDTH(DW), .AXI_STRB_WIDTH(SW), .MASTER_ID(4'h1),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .ddr_init_done(ddr_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .err(err), .err_clr(err_clr),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    typedef struct { logic [AW-1:0] addr; logic [BW-1:0] len; } cmd_t;
    typedef struct { logic [DW-1:0] data; logic last; } rbeat_t;

    cmd_t          exp_aw[$], exp_ar[$];
    logic [DW-1:0] exp_w[$];
    rbeat_t        exp_rd[$];
    logic [DW-1:0] m_mem[logic [AW-1:0]];
    logic [DW-1:0] s_mem[logic [AW-1:0]];

    int checks = 0, errors = 0;
    int aw_cycles = 0, w_hs_cnt = 0, rd_beat_cnt = 0, rd_last_cnt = 0;
    logic [AW-1:0] seen_awaddr = '0, seen_araddr = '0;
    logic [BW-1:0] seen_awlen = '0, seen_arlen = '0;
    logic [DW-1:0] last_rd_data = '0;
    logic          m_rd_phase = 1'b0;

    logic [IW-1:0] sl_bid, sl_rid;
    logic [1:0]    sl_bresp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk); #1;
    endtask

    // ---------------- slave responder ----------------
    initial begin : slave
        logic s_aw, s_w, s_b, s_ar, s_r;
        logic [AW-1:0] s_awaddr, s_araddr, wa, ra;
        logic [BW-1:0] s_awlen, s_arlen, wlen, rlen;
        logic [DW-1:0] s_wdata;
        int wcnt, rcnt;
        logic w_act;
        bvalid = 0; bid = 0; bresp = 0; wlast = 0;
        rvalid = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0;
        wa = 0; ra = 0; wlen = 0; rlen = 0; wcnt = 0; rcnt = 0; w_act = 0;
        forever begin
            @(negedge aclk);
            s_aw = awvalid && awready;  s_w = wvalid && wready;
            s_b  = bvalid && bready;    s_ar = arvalid && arready;
            s_r  = rvalid && rready;
            s_awaddr = awaddr; s_awlen = awlen; s_araddr = araddr; s_arlen = arlen;
            s_wdata = wdata;
            @(posedge aclk); #1;
            if (!aresetn) begin
                bvalid = 0; rvalid = 0; rlast = 0; wlast = 0; w_act = 0;
            end else begin
                if (s_b) bvalid = 0;
                if (s_aw) begin wa = s_awaddr; wlen = s_awlen; wcnt = 0; w_act = 1; end
                if (s_w) begin
                    s_mem[wa + AW'(wcnt)] = s_wdata;
                    if (wcnt == int'(wlen)) begin
                        w_act = 0; bvalid = 1; bid = sl_bid; bresp = sl_bresp;
                    end
                    wcnt++;
                end
                wlast = w_act && (wcnt == int'(wlen));
                if (s_ar) begin ra = s_araddr; rlen = s_arlen; rcnt = 0; rvalid = 1; end
                else if (s_r) begin
                    if (rcnt == int'(rlen)) rvalid = 0;
                    else rcnt++;
                end
                if (rvalid) begin
                    rdata = s_mem.exists(ra + AW'(rcnt)) ? s_mem[ra + AW'(rcnt)] : '0;
                    rlast = (rcnt == int'(rlen));
                    rid   = sl_rid;
                    rresp = 2'b00;
                end else begin
                    rlast = 0;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin : compare
        cmd_t   c;
        rbeat_t b;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                if (m_rd_phase) begin
                    chk("rready_mirror", rready, rd_ready);
                    chk("rd_valid_mirror", rd_valid, rvalid);
                end else begin
                    chk("rd_valid_idle", rd_valid, 1'b0);
                end
                if (rd_valid && rd_ready) begin
                    rd_beat_cnt++;
                    if (exp_rd.size() == 0) chk("rd_unexpected", 1'b1, 1'b0);
                    else begin
                        b = exp_rd.pop_front();
                        chk("rd_data", rd_data, b.data);
                        chk("rd_last", rd_last, b.last);
                        if (b.last) m_rd_phase = 1'b0;
                    end
                    if (rd_last) rd_last_cnt++;
                    last_rd_data = rd_data;
                end
                if (awvalid) begin
                    aw_cycles++;
                    chk("aw_ar_excl", arvalid, 1'b0);
                    if (exp_aw.size() == 0) chk("aw_unexpected", 1'b1, 1'b0);
                    else begin
                        c = exp_aw[0];
                        chk("awaddr", awaddr, c.addr);
                        chk("awlen", awlen, c.len);
                        chk("awid", awid, 4'h1);
                        if (awready) begin
                            seen_awaddr = awaddr; seen_awlen = awlen;
                            void'(exp_aw.pop_front());
                        end
                    end
                end
                if (wvalid && wready) begin
                    w_hs_cnt++;
                    if (exp_w.size() == 0) chk("w_unexpected", 1'b1, 1'b0);
                    else chk("wdata", wdata, exp_w.pop_front());
                end
                if (arvalid) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", 1'b1, 1'b0);
                    else begin
                        c = exp_ar[0];
                        chk("araddr", araddr, c.addr);
                        chk("arlen", arlen, c.len);
                        chk("arid", arid, 4'h1);
                        if (arready) begin
                            seen_araddr = araddr; seen_arlen = arlen;
                            void'(exp_ar.pop_front());
                            m_rd_phase = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_cmd(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] len);
        int n = 0;
        logic hs = 1'b0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = cmd_ready;
            @(posedge aclk); #1; n++;
        end
        cmd_valid = 0;
        chk("cmd_accept", hs, 1'b1);
    endtask

    task automatic wait_wr_hs();
        int n = 0;
        logic hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge aclk); hs = wr_valid && wr_ready;
            @(posedge aclk); #1; n++;
        end
        chk("wr_beat_hs", hs, 1'b1);
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin tick(); n++; end
        chk(name, busy, 1'b0);
    endtask

    task automatic pulse_clr();
        err_clr = 1; tick(); err_clr = 0;
        chk("err_cleared", err, 1'b0);
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [BW-1:0] len,
                               input logic [DW-1:0] base);
        cmd_t c;
        logic [DW-1:0] d;
        c.addr = addr & ~32'h7; c.len = len;
        exp_aw.push_back(c);
        for (int i = 0; i <= int'(len); i++) begin
            d = base * (i + 1);
            exp_w.push_back(d);
            m_mem[c.addr + AW'(i)] = d;
        end
        issue_cmd(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            wr_data = base * (i + 1); wr_valid = 1;
            wait_wr_hs();
        end
        wr_valid = 0;
        wait_idle(50, "wr_done");
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [BW-1:0] len,
                              input logic toggle);
        cmd_t   c;
        rbeat_t b;
        int     n = 0;
        c.addr = addr & ~32'h7; c.len = len;
        exp_ar.push_back(c);
        for (int i = 0; i <= int'(len); i++) begin
            b.data = m_mem.exists(c.addr + AW'(i)) ? m_mem[c.addr + AW'(i)] : '0;
            b.last = (i == int'(len));
            exp_rd.push_back(b);
        end
        issue_cmd(1'b0, addr, len);
        while (busy && n < 300) begin
            if (toggle) rd_ready = ~rd_ready;
            tick(); n++;
        end
        rd_ready = 1;
        chk("rd_done", busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int nhit;
        cmd_t c;
        aresetn = 0; ddr_init_done = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_strb = '1; wr_valid = 0; rd_ready = 1; err_clr = 0;
        awready = 1; wready = 1; arready = 1;
        sl_bid = 4'h1; sl_rid = 4'h1; sl_bresp = 2'b00;
        repeat (3) tick();
        chk("reset_outs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready,
                           rd_valid, rd_last, busy, err}, '0);
        aresetn = 1; tick();

        // basic write then read-back
        w_hs_cnt = 0;
        write_burst(32'h100, 6'd3, 128'h11);
        chk("wr1_awaddr", seen_awaddr, 32'h100);
        chk("wr1_awlen", seen_awlen, 6'd3);
        chk("wr1_beats", w_hs_cnt, 4);
        chk("wr1_err", err, 1'b0);

        rd_beat_cnt = 0; rd_last_cnt = 0;
        read_burst(32'h100, 6'd3, 1'b0);
        chk("rd1_araddr", seen_araddr, 32'h100);
        chk("rd1_arlen", seen_arlen, 6'd3);
        chk("rd1_beats", rd_beat_cnt, 4);
        chk("rd1_last_once", rd_last_cnt, 1);
        chk("rd1_final_data", last_rd_data, 128'h44);
        chk("rd1_drained", exp_rd.size(), 0);

        // back-pressured read
        write_burst(32'h300, 6'd7, 128'h1010);
        rd_beat_cnt = 0; rd_last_cnt = 0;
        read_burst(32'h300, 6'd7, 1'b1);
        chk("rd2_beats", rd_beat_cnt, 8);
        chk("rd2_last_once", rd_last_cnt, 1);
        chk("rd2_final_data", last_rd_data, 128'h8080);
        chk("rd2_drained", exp_rd.size(), 0);

        // unaligned command address
        write_burst(32'h107, 6'd1, 128'h99);
        chk("unaligned_awaddr", seen_awaddr, 32'h100);
        chk("unaligned_err", err, 1'b0);

        // calibration not done
        ddr_init_done = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h600; cmd_len = 0;
        nhit = 0;
        repeat (10) begin
            @(negedge aclk);
            if (cmd_ready || awvalid || arvalid || busy) nhit++;
            @(posedge aclk); #1;
        end
        cmd_valid = 0; tick(); ddr_init_done = 1;
        chk("init_gate", nhit, 0);

        // bad write response
        sl_bresp = 2'b10;
        write_burst(32'h400, 6'd0, 128'h55);
        sl_bresp = 2'b00;
        chk("bresp_err", err, 1'b1);
        pulse_clr();

        // bad read ID
        sl_rid = 4'h0;
        read_burst(32'h400, 6'd0, 1'b0);
        sl_rid = 4'h1;
        chk("rid_err", err, 1'b1);
        pulse_clr();

        // AW watchdog
        awready = 0; aw_cycles = 0;
        c.addr = 32'h500; c.len = 0; exp_aw.push_back(c);
        issue_cmd(1'b1, 32'h500, 6'd0);
        wait_idle(TMO + 50, "tmo_idle");
        chk("tmo_aw_cycles", aw_cycles, TMO);
        chk("tmo_err", err, 1'b1);
        chk("tmo_awvalid", awvalid, 1'b0);
        exp_aw.delete();
        awready = 1;
        pulse_clr();

        // asynchronous reset in the middle of a write burst
        c.addr = 32'h200; c.len = 7; exp_aw.push_back(c);
        for (int i = 0; i < 8; i++) exp_w.push_back(128'h77 * (i + 1));
        issue_cmd(1'b1, 32'h200, 6'd7);
        for (int i = 0; i < 2; i++) begin
            wr_data = 128'h77 * (i + 1); wr_valid = 1;
            wait_wr_hs();
        end
        wr_data = 128'h77 * 3;
        #2 aresetn = 0;
        #1 chk("rst_midw_outs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid,
                                 rready, rd_valid, rd_last, busy, err}, '0);
        wr_valid = 0;
        exp_w.delete(); exp_aw.delete();
        tick(); tick();
        aresetn = 1; tick();
        chk("rst_busy", busy, 1'b0);
        read_burst(32'h300, 6'd1, 1'b0);
        chk("post_rst_err", err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
